// File: rtl/sequential_divider_pkg.sv
// +----------------------------------------------------------------------+
// | divider_pkg : shared width, state and vector types for the divider    |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package divider_pkg;

  localparam int DW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef logic [2*DW-1:0] dividend_t;
  typedef logic [2*DW-1:0] quotient_t;
  typedef logic [DW-1:0]   divisor_t;
  typedef logic [DW-1:0]   rem_t;

endpackage

`default_nettype wire

// File: rtl/sequential_divider_if.sv
// +----------------------------------------------------------------------+
// | sequential_divider_if : operand and result valid/ready handshakes     |
// | Revision              : 1.0                                           |
// +----------------------------------------------------------------------+
`default_nettype none

interface sequential_divider_if #(
  parameter int DW = divider_pkg::DW
);

  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] quotient;
  logic [DW-1:0]   remainder;
  logic            div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

`default_nettype wire

// File: rtl/sequential_divider_div_step.sv
// +----------------------------------------------------------------------+
// | div_step : one combinational restoring-division iteration             |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module div_step #(
  parameter int DW = divider_pkg::DW
) (
  input  logic [DW:0]   rem_in,
  input  logic          bit_in,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   rem_out,
  output logic          q_bit
);

  logic [DW:0]   w_shift;
  logic [DW+1:0] w_diff;
  logic          w_borrow;
  logic          w_unused_rem_msb;

  // The incoming MSB is shifted out; a valid partial remainder never needs it.
  assign w_unused_rem_msb = rem_in[DW];

  assign w_shift  = {rem_in[DW-1:0], bit_in};
  assign w_diff   = {1'b0, w_shift} - {2'b00, divisor};
  assign w_borrow = w_diff[DW+1];

  assign q_bit   = ~w_borrow;
  assign rem_out = w_borrow ? w_shift : w_diff[DW:0];

endmodule

`default_nettype wire

// File: rtl/sequential_divider.sv
// +----------------------------------------------------------------------+
// | sequential_divider : multi-cycle restoring divider, 2*DW / DW bits    |
// | Option DIV_ZERO_FAST_EN: zero divisor completes one cycle after accept|
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sequential_divider
  import divider_pkg::*;
#(
  parameter int DW = divider_pkg::DW
) (
  input  logic               clk,
  input  logic               rst_n,
  sequential_divider_if.slave bus
);

  localparam int c_cnt_w = $clog2(2*DW);

  div_state_t          r_state;
  div_state_t          w_state_next;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [DW:0]         r_rem;
  logic [2*DW-1:0]     r_q;
  logic [DW-1:0]       r_divisor;
  logic                r_zero;
  logic [2*DW-1:0]     r_quotient;
  logic [DW-1:0]       r_remainder;
  logic                r_dbz;

  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_accept;
  logic                w_zero_in;
  logic                w_fast;
  logic [DW:0]         w_rem_next;
  logic                w_qbit;

  assign w_accept  = bus.in_valid && (r_state == IDLE);
  assign w_zero_in = (bus.divisor == '0);

`ifdef DIV_ZERO_FAST_EN
  assign w_fast = w_zero_in;
`else
  assign w_fast = 1'b0;
`endif

  div_step #(.DW(DW)) u_step (
    .rem_in  (r_rem),
    .bit_in  (r_q[2*DW-1]),
    .divisor (r_divisor),
    .rem_out (w_rem_next),
    .q_bit   (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = w_fast ? DONE : RUN;
      end
      RUN: begin
        if (r_cnt == '0) w_state_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      r_zero      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_rem     <= '0;
      r_q       <= bus.dividend;
      r_divisor <= bus.divisor;
      r_zero    <= w_zero_in;
      r_cnt     <= c_cnt_w'(2*DW-1);
      if (w_fast) begin
        r_quotient  <= '1;
        r_remainder <= bus.dividend[DW-1:0];
        r_dbz       <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_rem <= w_rem_next;
      r_q   <= {r_q[2*DW-2:0], w_qbit};
      // Result registers load only on the final step so they stay stable otherwise.
      if (r_cnt == '0) begin
        r_quotient  <= {r_q[2*DW-2:0], w_qbit};
        r_remainder <= w_rem_next[DW-1:0];
        r_dbz       <= r_zero;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_sequential_divider.sv
// +----------------------------------------------------------------------+
// | tb_sequential_divider : directed and exhaustive checks of the divider |
// | Revision              : 1.0                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sequential_divider;
  import divider_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sequential_divider_if #(.DW(4)) bus ();

  sequential_divider #(.DW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef DIV_ZERO_FAST_EN
  localparam int c_zero_lat = 1;
`else
  localparam int c_zero_lat = 9;
`endif

  int         errors = 0;
  int         checks = 0;
  int         lat;
  logic [7:0] q;
  logic [3:0] r;
  logic       dbz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Latency counts rising edges from the accepting edge (1) to the one that raises out_valid.
  task automatic wait_result();
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk("result_timeout", {31'd0, bus.out_valid}, 32'd1);
    q   = bus.quotient;
    r   = bus.remainder;
    dbz = bus.div_by_zero;
  endtask

  task automatic op(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    bus.in_valid = 1'b0;
    wait_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  {31'd0, bus.in_ready},    32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid},   32'd0);
    chk("rst_quotient",  {24'd0, bus.quotient},    32'd0);
    chk("rst_remainder", {28'd0, bus.remainder},   32'd0);
    chk("rst_dbz",       {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(8'd225, 4'd15);
    chk("225/15 q",   {24'd0, q}, 32'd15);
    chk("225/15 r",   {28'd0, r}, 32'd0);
    chk("225/15 dbz", {31'd0, dbz}, 32'd0);
    chk("225/15 lat", lat, 32'd9);

    op(8'd255, 4'd1);
    chk("255/1 q", {24'd0, q}, 32'd255);
    chk("255/1 r", {28'd0, r}, 32'd0);

    op(8'd100, 4'd7);
    chk("100/7 q", {24'd0, q}, 32'd14);
    chk("100/7 r", {28'd0, r}, 32'd2);

    op(8'd0, 4'd9);
    chk("0/9 q", {24'd0, q}, 32'd0);
    chk("0/9 r", {28'd0, r}, 32'd0);

    op(8'hA5, 4'd0);
    chk("A5/0 q",   {24'd0, q}, 32'hFF);
    chk("A5/0 r",   {28'd0, r}, 32'h5);
    chk("A5/0 dbz", {31'd0, dbz}, 32'd1);
    chk("A5/0 lat", lat, c_zero_lat);

    // Backpressure with a competing request held on in_valid throughout.
    @(negedge clk);
    bus.dividend = 8'd100;
    bus.divisor  = 4'd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    bus.dividend = 8'd50;
    bus.divisor  = 4'd5;
    wait_result();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_q",         {24'd0, bus.quotient},  32'd14);
      chk("bp_r",         {28'd0, bus.remainder}, 32'd2);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_hs_in_ready",  {31'd0, bus.in_ready},  32'd1);
    @(posedge clk);
    lat = 1;
    #1;
    bus.in_valid = 1'b0;
    wait_result();
    chk("bp_next_q",   {24'd0, q}, 32'd10);
    chk("bp_next_r",   {28'd0, r}, 32'd0);
    chk("bp_next_lat", lat, 32'd9);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Reset in the middle of a RUN discards the pending operation.
    @(negedge clk);
    bus.dividend = 8'd200;
    bus.divisor  = 4'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("mid_rst_quotient",  {24'd0, bus.quotient},  32'd0);
    chk("mid_rst_remainder", {28'd0, bus.remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(8'd200, 4'd3);
    chk("200/3 q",   {24'd0, q}, 32'd66);
    chk("200/3 r",   {28'd0, r}, 32'd2);
    chk("200/3 dbz", {31'd0, dbz}, 32'd0);

    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        op(8'(a), 4'(b));
        chk($sformatf("exh %0d/%0d identity", a, b),
            {31'd0, (((32'(q) * 32'(b)) + 32'(r)) == 32'(a)) && (32'(r) < 32'(b)) && (dbz === 1'b0)},
            32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
